// File: rtl/sa_pkg.sv
// Shared constants, FSM state type and skew addressing for the 4x4 systolic job sequencer.
package sa_pkg;

   localparam int unsigned DW        = 32;
   localparam int unsigned N         = 4;
   localparam int unsigned LW        = $clog2(N);
   localparam int unsigned AW        = 2 * LW;
   localparam int unsigned STEP_W    = 3;
   localparam int unsigned FEED_LAST = 2 * N - 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } sa_state_t;

   typedef struct packed {
      logic          vld;
      logic [AW-1:0] idx;
   } skew_t;

   // Element feeding `lane` at step t: A rows go row-major (by_col=0), B columns column-major (by_col=1).
   function automatic skew_t skew_idx(input logic [STEP_W-1:0] t,
                                      input logic [LW-1:0]     lane,
                                      input logic              by_col);
      skew_t             r;
      logic [STEP_W-1:0] k;
      k     = t - STEP_W'(lane);
      r.vld = (t >= STEP_W'(lane)) && (k < STEP_W'(N));
      r.idx = by_col ? {k[LW-1:0], lane} : {lane, k[LW-1:0]};
      return r;
   endfunction

endpackage

// File: rtl/sa_mat_buf.sv
// One NxN operand matrix: single write port, N combinational read ports, async clear.
module sa_mat_buf #(
   parameter int unsigned DW = sa_pkg::DW,
   parameter int unsigned N  = sa_pkg::N,
   parameter int unsigned AW = sa_pkg::AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [DW-1:0]   wr_data,
   input  logic [N*AW-1:0] rd_addr,
   output logic [N*DW-1:0] rd_data
);

   logic [DW-1:0] mem [N*N];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N * N; i++) mem[i] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < N; p++) rd_data[p*DW +: DW] = mem[rd_addr[p*AW +: AW]];
   end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer: buffers A/B, clears the PE array, feeds skewed rows/columns, waits for drain, pulses done.
module systolic_ctrl #(
   parameter int unsigned DW    = sa_pkg::DW,
   parameter int unsigned N     = sa_pkg::N,
   parameter int unsigned DRAIN = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic                  ld_sel,
   input  logic [sa_pkg::AW-1:0] ld_addr,
   input  logic [DW-1:0]         ld_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  arr_rst,
   output logic [N*DW-1:0]       west_data,
   output logic [N*DW-1:0]       north_data
);

   import sa_pkg::*;

   localparam int unsigned DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   sa_state_t         state, state_nxt;
   logic [STEP_W-1:0] step, step_nxt;
   logic [DCW-1:0]    dcnt, dcnt_nxt;

   logic              wr_ok;
   logic [N*AW-1:0]   a_rd_addr, b_rd_addr;
   logic [N*DW-1:0]   a_rd, b_rd;
   logic [N-1:0]      a_vld, b_vld;

   logic              busy_nxt, done_nxt, arr_rst_nxt;
   logic [N*DW-1:0]   west_nxt, north_nxt;

   // Held low while reset is asserted even though the state register already reads IDLE.
   assign ld_ready = (state == ST_IDLE) && rst;
   assign wr_ok    = ld_valid && ld_ready;

   sa_mat_buf #(.DW(DW), .N(N), .AW(AW)) u_buf_a (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok && !ld_sel),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_addr (a_rd_addr),
      .rd_data (a_rd)
   );

   sa_mat_buf #(.DW(DW), .N(N), .AW(AW)) u_buf_b (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok && ld_sel),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_addr (b_rd_addr),
      .rd_data (b_rd)
   );

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         step  <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   // Next-state and counter sequencing
   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      dcnt_nxt  = dcnt;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_CLEAR;
               step_nxt  = '0;
               dcnt_nxt  = '0;
            end
         end
         ST_CLEAR: begin
            state_nxt = ST_FEED;
            step_nxt  = '0;
         end
         ST_FEED: begin
            if (step == STEP_W'(FEED_LAST)) begin
               state_nxt = ST_DRAIN;
               dcnt_nxt  = '0;
            end else begin
               step_nxt = step + STEP_W'(1);
            end
         end
         ST_DRAIN: begin
            if (dcnt == DCW'(DRAIN - 1)) state_nxt = ST_DONE;
            else                         dcnt_nxt  = dcnt + DCW'(1);
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Buffer read addresses follow the step the registered outputs will show next cycle
   always_comb begin
      skew_t sa, sb;
      a_rd_addr = '0;
      b_rd_addr = '0;
      a_vld     = '0;
      b_vld     = '0;
      for (int p = 0; p < N; p++) begin
         sa = skew_idx(step_nxt, LW'(p), 1'b0);
         sb = skew_idx(step_nxt, LW'(p), 1'b1);
         a_rd_addr[p*AW +: AW] = sa.idx;
         b_rd_addr[p*AW +: AW] = sb.idx;
         a_vld[p]              = sa.vld;
         b_vld[p]              = sb.vld;
      end
   end

   // Output decode from next state
   always_comb begin
      busy_nxt    = (state_nxt != ST_IDLE);
      done_nxt    = (state_nxt == ST_DONE);
      arr_rst_nxt = (state_nxt != ST_CLEAR);
      west_nxt    = '0;
      north_nxt   = '0;
      if (state_nxt == ST_FEED) begin
         for (int p = 0; p < N; p++) begin
            if (a_vld[p]) west_nxt[p*DW +: DW]  = a_rd[p*DW +: DW];
            if (b_vld[p]) north_nxt[p*DW +: DW] = b_rd[p*DW +: DW];
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         arr_rst    <= 1'b0;
         west_data  <= '0;
         north_data <= '0;
      end else begin
         busy       <= busy_nxt;
         done       <= done_nxt;
         arr_rst    <= arr_rst_nxt;
         west_data  <= west_nxt;
         north_data <= north_nxt;
      end
   end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: phase table, skew table, feed scoreboard and a PE array model.
module tb_systolic_ctrl;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int BW = N * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ld_valid = 1'b0;
   logic          ld_ready;
   logic          ld_sel = 1'b0;
   logic [3:0]    ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          start = 1'b0;
   logic          busy, done, arr_rst;
   logic [BW-1:0] west_data, north_data;

   always #5 clk = ~clk;

   systolic_ctrl #(.DW(DW), .N(N), .DRAIN(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_sel     (ld_sel),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .arr_rst    (arr_rst),
      .west_data  (west_data),
      .north_data (north_data)
   );

   typedef struct {
      bit            busy;
      bit            done;
      bit            arr_rst;
      bit            ldr;
      logic [BW-1:0] west;
      logic [BW-1:0] north;
   } exp_t;

   typedef struct {
      int c_lo;
      int c_hi;
      bit busy;
      bit done;
      bit arr_rst;
      bit ldr;
      bit feed;
   } phase_t;

   typedef struct {
      int cyc;
      bit north;
      int lane;
      int val;
   } skew_vec_t;

   exp_t        sbq[$];
   phase_t      phases[5];
   skew_vec_t   skv[10];
   int unsigned a_m[16];
   int unsigned b_m[16];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_at = -1;
   int          job_s0 = 0;

   always @(posedge clk) cyc++;
   always @(negedge clk) if (done) begin done_cnt++; done_at = cyc; end

   // Output-stationary PE array: pass-through and accumulator registered on the same edge
   logic [DW-1:0] pe_acc [N][N];
   logic [DW-1:0] pe_w   [N][N];
   logic [DW-1:0] pe_n   [N][N];

   always @(posedge clk) begin
      logic [DW-1:0] win, nin;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (j == 0) win = west_data[i*DW +: DW];
            else        win = pe_w[i][j-1];
            if (i == 0) nin = north_data[j*DW +: DW];
            else        nin = pe_n[i-1][j];
            if (!arr_rst) begin
               pe_acc[i][j] <= '0;
               pe_w[i][j]   <= '0;
               pe_n[i][j]   <= '0;
            end else begin
               pe_acc[i][j] <= pe_acc[i][j] + win * nin;
               pe_w[i][j]   <= win;
               pe_n[i][j]   <= nin;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] feed_w(input int t);
      logic [BW-1:0] v = '0;
      for (int i = 0; i < N; i++)
         if (t - i >= 0 && t - i < N) v[i*DW +: DW] = a_m[i*N + t - i];
      return v;
   endfunction

   function automatic logic [BW-1:0] feed_n(input int t);
      logic [BW-1:0] v = '0;
      for (int j = 0; j < N; j++)
         if (t - j >= 0 && t - j < N) v[j*DW +: DW] = b_m[(t - j)*N + j];
      return v;
   endfunction

   task automatic push_job();
      exp_t e;
      for (int c = 1; c <= 13; c++) begin
         foreach (phases[p]) begin
            if (c >= phases[p].c_lo && c <= phases[p].c_hi) begin
               e.busy    = phases[p].busy;
               e.done    = phases[p].done;
               e.arr_rst = phases[p].arr_rst;
               e.ldr     = phases[p].ldr;
               e.west    = phases[p].feed ? feed_w(c - 2) : '0;
               e.north   = phases[p].feed ? feed_n(c - 2) : '0;
            end
         end
         sbq.push_back(e);
      end
   endtask

   task automatic wr(input bit sel, input int addr, input int unsigned data);
      @(posedge clk); #1;
      ld_valid = 1'b1;
      ld_sel   = sel;
      ld_addr  = 4'(addr);
      ld_data  = data;
      if (sel) b_m[addr] = data;
      else     a_m[addr] = data;
      @(negedge clk);
      chk($sformatf("wr ld_ready a%0d", addr), BW'(ld_ready), BW'(1));
   endtask

   // One job from cycle 0 to cycle 13; chained means its start was driven in the previous job's cycle 13
   task automatic job(input bit chained, input int extra_start, input bit chain_next,
                      input bit hold_ld, input int wr_a0, input bit skew, input bit res);
      exp_t e;
      if (!chained) begin
         @(posedge clk); #1;
         start    = 1'b1;
         ld_valid = 1'b0;
         if (wr_a0 >= 0) begin
            ld_valid = 1'b1;
            ld_sel   = 1'b0;
            ld_addr  = 4'd0;
            ld_data  = 32'(wr_a0);
            a_m[0]   = 32'(wr_a0);
         end
      end
      job_s0 = cyc;
      push_job();
      for (int c = 1; c <= 13; c++) begin
         @(posedge clk); #1;
         start    = (c == extra_start) || (c == 13 && chain_next);
         ld_valid = hold_ld;
         if (hold_ld) begin
            ld_sel  = 1'b1;
            ld_addr = 4'd0;
            ld_data = 32'd99;
         end
         @(negedge clk);
         e = sbq.pop_front();
         chk($sformatf("c%0d busy", c),     BW'(busy),     BW'(e.busy));
         chk($sformatf("c%0d done", c),     BW'(done),     BW'(e.done));
         chk($sformatf("c%0d arr_rst", c),  BW'(arr_rst),  BW'(e.arr_rst));
         chk($sformatf("c%0d ld_ready", c), BW'(ld_ready), BW'(e.ldr));
         chk($sformatf("c%0d west", c),     west_data,     e.west);
         chk($sformatf("c%0d north", c),    north_data,    e.north);
         if (skew) begin
            foreach (skv[k]) begin
               if (skv[k].cyc == c) begin
                  if (skv[k].north)
                     chk($sformatf("skew c%0d north%0d", c, skv[k].lane),
                         BW'(north_data[skv[k].lane*DW +: DW]), BW'(skv[k].val));
                  else
                     chk($sformatf("skew c%0d west%0d", c, skv[k].lane),
                         BW'(west_data[skv[k].lane*DW +: DW]), BW'(skv[k].val));
               end
            end
         end
         if (wr_a0 >= 0 && c == 2)
            chk("write+start west0", BW'(west_data[DW-1:0]), BW'(wr_a0));
         if (res && c == 12) begin
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  logic [DW-1:0] s = '0;
                  for (int k = 0; k < N; k++) s += a_m[i*N + k] * b_m[k*N + j];
                  chk($sformatf("result%0d", i*N + j), BW'(pe_acc[i][j]), BW'(s));
               end
            end
            chk("result15 value", BW'(pe_acc[3][3]), BW'(7));
         end
      end
      if (hold_ld) b_m[0] = 99;
   endtask

   initial begin
      int d0, s_first;

      phases[0] = '{1,  1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      phases[1] = '{2,  8,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      phases[2] = '{9,  11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      phases[3] = '{12, 12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      phases[4] = '{13, 13, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

      skv[0] = '{2, 1'b0, 0, 1};
      skv[1] = '{2, 1'b1, 0, 1};
      skv[2] = '{2, 1'b0, 1, 0};
      skv[3] = '{2, 1'b1, 3, 0};
      skv[4] = '{3, 1'b1, 0, 5};
      skv[5] = '{3, 1'b1, 1, 2};
      skv[6] = '{3, 1'b0, 0, 0};
      skv[7] = '{3, 1'b0, 1, 0};
      skv[8] = '{8, 1'b0, 3, 1};
      skv[9] = '{8, 1'b1, 3, 16};

      foreach (a_m[i]) begin a_m[i] = 0; b_m[i] = 0; end

      // Power-on reset
      #2;
      chk("rst busy",     BW'(busy),     BW'(0));
      chk("rst done",     BW'(done),     BW'(0));
      chk("rst arr_rst",  BW'(arr_rst),  BW'(0));
      chk("rst ld_ready", BW'(ld_ready), BW'(0));
      chk("rst west",     west_data,     '0);
      chk("rst north",    north_data,    '0);
      #20 rst = 1'b1;
      #1 chk("post-rst ld_ready", BW'(ld_ready), BW'(1));

      // Skew: A = identity, B[k][j] = 4k+j+1
      for (int i = 0; i < 16; i++) wr(1'b0, i, (i / 4 == i % 4) ? 1 : 0);
      for (int i = 0; i < 16; i++) wr(1'b1, i, i + 1);
      job(1'b0, -1, 1'b0, 1'b0, -1, 1'b1, 1'b0);

      // End-to-end: A[i][k] = i+k+1, B = identity
      for (int i = 0; i < 16; i++) wr(1'b0, i, i / 4 + i % 4 + 1);
      for (int i = 0; i < 16; i++) wr(1'b1, i, (i / 4 == i % 4) ? 1 : 0);
      job(1'b0, -1, 1'b0, 1'b0, -1, 1'b0, 1'b1);

      // Back-to-back: start in cycle 5 ignored, start in cycle 13 launches the next job
      d0 = done_cnt;
      job(1'b0, 5, 1'b1, 1'b0, -1, 1'b0, 1'b0);
      s_first = job_s0;
      job(1'b1, -1, 1'b0, 1'b0, -1, 1'b0, 1'b1);
      chk("b2b done count", BW'(done_cnt - d0), BW'(2));
      chk("b2b done cycle", BW'(done_at - s_first), BW'(25));

      // Write held during a job lands in cycle 13; then write+start in one IDLE cycle
      job(1'b0, -1, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      job(1'b0, -1, 1'b0, 1'b0, 7, 1'b0, 1'b0);

      // Async reset mid-FEED
      @(posedge clk); #1 start = 1'b1; ld_valid = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #3;
      chk("pre-rst busy", BW'(busy), BW'(1));
      rst = 1'b0;
      #1;
      chk("mid rst busy",     BW'(busy),     BW'(0));
      chk("mid rst done",     BW'(done),     BW'(0));
      chk("mid rst arr_rst",  BW'(arr_rst),  BW'(0));
      chk("mid rst ld_ready", BW'(ld_ready), BW'(0));
      chk("mid rst west",     west_data,     '0);
      chk("mid rst north",    north_data,    '0);
      @(posedge clk); #2 rst = 1'b1;
      #1 chk("mid post-rst ld_ready", BW'(ld_ready), BW'(1));
      foreach (a_m[i]) begin a_m[i] = 0; b_m[i] = 0; end
      job(1'b0, -1, 1'b0, 1'b0, -1, 1'b0, 1'b0);

      @(posedge clk); #1 start = 1'b0; ld_valid = 1'b0;
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
